// File: rtl/thermo_stream_if.sv
// Valid/ready stream bundle between the classifier register stage and the
// result collector: thermometer codes in, decoded levels out.
interface thermo_stream_if #(
    parameter int WIDTH = 9,
    parameter int CW    = $clog2(WIDTH + 1)
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    outp;
    logic             out_err;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out_valid, outp, out_err
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out_valid, outp, out_err
    );
endinterface

// File: rtl/thermo_stream_decoder.sv
// Thermometer-code to binary decoder with a one-deep output register and
// per-window sum/max/error statistics over transferred samples.
module thermo_stream_decoder #(
    parameter int WIDTH  = 9,
    parameter int WINDOW = 8,
    localparam int CW    = $clog2(WIDTH + 1),
    localparam int SW    = CW + $clog2(WINDOW),
    localparam int EW    = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    thermo_stream_if.slave bus,
    output logic          win_valid,
    output logic [SW-1:0] win_sum,
    output logic [CW-1:0] win_max,
    output logic [EW-1:0] win_err_cnt
);
    localparam int NW = $clog2(WINDOW);

    logic [WIDTH-1:0] run;
    logic [CW-1:0]    level_next;
    logic             err_next;

    logic             out_valid_reg;
    logic [CW-1:0]    outp_reg;
    logic             out_err_reg;

    logic [NW-1:0]    cnt_reg;
    logic [SW-1:0]    acc_sum_reg;
    logic [CW-1:0]    acc_max_reg;
    logic [EW-1:0]    acc_err_reg;
    logic             win_valid_reg;
    logic [SW-1:0]    win_sum_reg;
    logic [CW-1:0]    win_max_reg;
    logic [EW-1:0]    win_err_reg;

    logic [SW-1:0]    sum_next;
    logic [CW-1:0]    max_next;
    logic [EW-1:0]    errc_next;

    logic             in_fire;
    logic             out_fire;

    // run[i] is set when bits 0..i are all ones, so run is the legal prefix of inp
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_run
            assign run[gi] = &bus.inp[gi:0];
        end
    endgenerate

    always_comb begin
        level_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level_next = level_next + CW'(run[i]);
        end
        // any set bit outside the legal prefix is a bubble
        err_next = |(bus.inp & ~run);
    end

    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = out_valid_reg && bus.out_ready;

    assign sum_next  = acc_sum_reg + SW'(outp_reg);
    assign max_next  = (outp_reg > acc_max_reg) ? outp_reg : acc_max_reg;
    assign errc_next = acc_err_reg + EW'(out_err_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            outp_reg      <= '0;
            out_err_reg   <= 1'b0;
            cnt_reg       <= '0;
            acc_sum_reg   <= '0;
            acc_max_reg   <= '0;
            acc_err_reg   <= '0;
            win_valid_reg <= 1'b0;
            win_sum_reg   <= '0;
            win_max_reg   <= '0;
            win_err_reg   <= '0;
        end else begin
            if (in_fire) begin
                out_valid_reg <= 1'b1;
                outp_reg      <= level_next;
                out_err_reg   <= err_next;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end

            win_valid_reg <= 1'b0;
            if (out_fire) begin
                if (cnt_reg == NW'(WINDOW - 1)) begin
                    // the completing sample goes straight into the published result
                    win_valid_reg <= 1'b1;
                    win_sum_reg   <= sum_next;
                    win_max_reg   <= max_next;
                    win_err_reg   <= errc_next;
                    cnt_reg       <= '0;
                    acc_sum_reg   <= '0;
                    acc_max_reg   <= '0;
                    acc_err_reg   <= '0;
                end else begin
                    cnt_reg       <= cnt_reg + NW'(1);
                    acc_sum_reg   <= sum_next;
                    acc_max_reg   <= max_next;
                    acc_err_reg   <= errc_next;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.outp      = outp_reg;
    assign bus.out_err   = out_err_reg;
    assign win_valid     = win_valid_reg;
    assign win_sum       = win_sum_reg;
    assign win_max       = win_max_reg;
    assign win_err_cnt   = win_err_reg;
endmodule
